// File: rtl/mist_spi_master.sv
// mist_spi_master: MiST user_io SPI master (mode 0, MSB first) sending a command byte plus len streamed data bytes.
module mist_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       mist_sck,
  output logic       mist_mosi,
  output logic       mist_confdata0,
  input  logic       mist_miso
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, LOAD, TRAIL} state_t;
  state_t state, state_nx;
  logic [W-1:0] div_cnt;
  logic [3:0] half;
  logic [7:0] tx_sr, rx_sr, remain;
  logic is_data, tick, byte_end;
  assign busy = state != IDLE;
  assign mist_confdata0 = state == IDLE;
  assign tx_ready = state == LOAD;
  assign mist_mosi = tx_sr[7];
  always_comb begin
    tick = div_cnt == DIV_LAST;
    byte_end = state == SHIFT && tick && half == 4'd15;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LEAD : IDLE;
      LEAD:    state_nx = tick ? SHIFT : LEAD;
      SHIFT:   state_nx = byte_end ? (remain != 8'd0 ? LOAD : TRAIL) : SHIFT;
      LOAD:    state_nx = tx_valid ? SHIFT : LOAD;
      TRAIL:   state_nx = tick ? IDLE : TRAIL;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      state <= IDLE;
      div_cnt <= '0;
      half <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      remain <= '0;
      is_data <= 1'b0;
      mist_sck <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      div_cnt <= (state inside {LEAD, SHIFT, TRAIL}) && !tick ? div_cnt + 1'b1 : '0;
      rx_valid <= byte_end && is_data;
      done <= state == TRAIL && tick;
      if (state == IDLE && start) begin
        tx_sr <= cmd;
        remain <= len;
        is_data <= 1'b0;
      end
      // even half-periods end in a rising edge, odd ones in a falling edge
      if (state == SHIFT && tick) begin
        half <= half + 4'd1;
        mist_sck <= ~mist_sck;
        if (!half[0]) rx_sr <= {rx_sr[6:0], mist_miso};
        else if (half != 4'd15) tx_sr <= {tx_sr[6:0], 1'b0};
      end
      if (byte_end && is_data) rx_data <= rx_sr;
      if (state == LOAD && tx_valid) begin
        tx_sr <= tx_data;
        remain <= remain - 8'd1;
        is_data <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mist_spi_master.sv
// tb_mist_spi_master: checks two dividers (4 and 2) against a cycle-level waveform model and an SPI responder.
module tb_mist_spi_master;
  typedef logic [5:0] wv_t; // {select, sck, busy, done, tx_ready, rx_valid}
  localparam wv_t IDLE_WV = 6'b100000;
  logic clk50mhz = 1'b0;
  logic reset = 1'b1;
  logic [1:0] start = 2'b00;
  logic [7:0] cmd = 8'h00;
  logic [7:0] len = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic miso = 1'b0;
  logic [1:0] tx_ready, rx_valid, busy, done, sck, mosi, cs;
  logic [7:0] rx_d [2];
  logic sel = 1'b0;
  logic armed = 1'b0;
  int checks = 0;
  int errors = 0;
  wv_t act, oth;
  wv_t exp_q[$];
  logic [7:0] rx_exp[$], resp[$], txq[$], got[$];
  int stall_cfg = 0;
  int low_cnt = 0, done_cnt = 0, rxv_cnt = 0, rise_cnt = 0;

  always #5 clk50mhz = ~clk50mhz;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    mist_spi_master #(.CLK_DIV(g == 0 ? 4 : 2)) dut (
      .clk50mhz(clk50mhz), .reset(reset), .start(start[g]), .cmd(cmd), .len(len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready[g]), .rx_data(rx_d[g]),
      .rx_valid(rx_valid[g]), .busy(busy[g]), .done(done[g]), .mist_sck(sck[g]),
      .mist_mosi(mosi[g]), .mist_confdata0(cs[g]), .mist_miso(miso));
  end

  assign act = {cs[sel], sck[sel], busy[sel], done[sel], tx_ready[sel], rx_valid[sel]};
  assign oth = {cs[~sel], sck[~sel], busy[~sel], done[~sel], tx_ready[~sel], rx_valid[~sel]};

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, a, r);
    end
  endtask

  // Expected per-cycle outputs, starting with the accept cycle T0.
  task automatic build(input int div, input int n, input int stall);
    exp_q.push_back(IDLE_WV);
    repeat (div) exp_q.push_back(6'b001000);
    for (int b = 0; b <= n; b++) begin
      for (int h = 0; h < 16 * div; h++)
        exp_q.push_back({1'b0, 1'((h / div) % 2), 1'b1, 3'b000});
      for (int c = 0; c < (b < n ? 1 + (b == 0 ? stall : 0) : div); c++)
        exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 1'(b < n), 1'(b > 0 && c == 0)});
    end
    exp_q.push_back(6'b100100);
  endtask

  // Compare process plus the user_io responder (drives MISO, collects MOSI bytes).
  logic [7:0] s_in = 8'h00, s_out = 8'h00;
  int s_bits = 0, s_idx = 0;
  logic prev_sck = 1'b0, prev_mosi = 1'b0, hold = 1'b0;
  always @(negedge clk50mhz) begin
    wv_t e;
    if (armed) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : IDLE_WV;
      check("wave", act, e);
      check("other_idle", oth, IDLE_WV);
      if (rx_valid[sel]) begin
        check("rx_expected", rx_exp.size() != 0, 1);
        if (rx_exp.size() != 0) check("rx_data", rx_d[sel], rx_exp.pop_front());
      end
      if (!cs[sel]) low_cnt++;
      if (done[sel]) done_cnt++;
      if (rx_valid[sel]) rxv_cnt++;
    end
    if (cs[sel]) begin
      s_bits = 0;
      s_idx = 0;
      s_out = resp.size() != 0 ? resp[0] : 8'h00;
    end else if (sck[sel] && !prev_sck) begin
      check("mosi_setup", mosi[sel], prev_mosi);
      s_in = {s_in[6:0], mosi[sel]};
      hold = mosi[sel];
      rise_cnt++;
      s_bits++;
      if (s_bits == 8) begin
        got.push_back(s_in);
        s_bits = 0;
      end
    end else if (sck[sel]) begin
      check("mosi_hold", mosi[sel], hold);
    end else if (prev_sck) begin
      if (s_bits == 0) begin
        s_idx++;
        s_out = s_idx < resp.size() ? resp[s_idx] : 8'h00;
      end else s_out = {s_out[6:0], 1'b0};
    end
    miso = s_out[7];
    prev_sck = sck[sel];
    prev_mosi = mosi[sel];
  end

  // Data source: holds tx_valid low for stall_cfg LOAD cycles, then streams txq.
  int f_idx = 0, f_stall = 0;
  logic f_hs = 1'b0;
  always @(negedge clk50mhz) begin
    if (cs[sel]) begin
      f_idx = 0;
      f_hs = 1'b0;
      f_stall = stall_cfg;
    end else if (f_hs) begin
      f_idx++;
      f_hs = 1'b0;
    end
    if (tx_ready[sel] && f_stall > 0) begin
      tx_valid = 1'b0;
      f_stall--;
    end else begin
      tx_valid = 1'b1;
      tx_data = f_idx < txq.size() ? txq[f_idx] : 8'h00;
      f_hs = tx_ready[sel];
    end
  end

  task automatic launch(input logic s, input logic [7:0] c, input int n, input int stall);
    sel = s;
    stall_cfg = stall;
    build(s ? 2 : 4, n, stall);
    rx_exp.delete();
    for (int k = 1; k <= n; k++) rx_exp.push_back(resp[k]);
    cmd = c;
    len = 8'(n);
    start[s] = 1'b1;
    @(posedge clk50mhz); #1;
    start[s] = 1'b0;
  endtask

  task automatic run(input logic s, input logic [7:0] c, input int n, input int stall,
                     input bit poke, input int low_req, input string tag);
    int g0, r0, l0, d0, v0;
    g0 = got.size(); r0 = rise_cnt; l0 = low_cnt; d0 = done_cnt; v0 = rxv_cnt;
    launch(s, c, n, stall);
    if (poke) begin
      repeat (40) @(posedge clk50mhz);
      #1;
      cmd = 8'hFF;
      len = 8'd9;
      start[s] = 1'b1;
      @(posedge clk50mhz); #1;
      start[s] = 1'b0;
    end
    for (int k = 0; k < 20000 && exp_q.size() != 0; k++) @(posedge clk50mhz);
    repeat (3) @(posedge clk50mhz);
    #1;
    check({tag, "_select_low"}, low_cnt - l0, low_req);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_rx_valid_count"}, rxv_cnt - v0, n);
    check({tag, "_sck_rises"}, rise_cnt - r0, 8 * (n + 1));
    check({tag, "_bytes"}, got.size() - g0, n + 1);
    for (int k = 0; k <= n && g0 + k < got.size(); k++)
      check({tag, "_mosi_byte"}, got[g0 + k], k == 0 ? c : txq[k - 1]);
    check({tag, "_rx_left"}, rx_exp.size(), 0);
  endtask

  initial begin
    int r0, d0, v0;
    @(posedge clk50mhz); #1;
    armed = 1'b1;
    check("reset_rx_data0", rx_d[0], 8'h00);
    check("reset_rx_data1", rx_d[1], 8'h00);
    check("reset_mosi", mosi, 2'b00);
    repeat (2) @(posedge clk50mhz);
    #1;
    reset = 1'b0;
    resp = '{8'h99};
    run(1'b0, 8'h1E, 0, 0, 1'b0, 72, "cmd_only");
    txq = '{8'hA5, 8'h3C};
    resp = '{8'h99, 8'hC3, 8'h5A};
    run(1'b1, 8'h15, 2, 0, 1'b0, 102, "two_bytes");
    run(1'b1, 8'h15, 2, 20, 1'b0, 122, "stall");
    run(1'b1, 8'h15, 2, 0, 1'b1, 102, "start_busy");
    r0 = rise_cnt; d0 = done_cnt; v0 = rxv_cnt;
    launch(1'b1, 8'h15, 2, 0);
    for (int k = 0; k < 500 && rise_cnt - r0 < 11; k++) begin
      @(negedge clk50mhz); #1;
    end
    check("reset_mid_rises", rise_cnt - r0, 11);
    reset = 1'b1;
    exp_q.delete();
    rx_exp.delete();
    @(posedge clk50mhz); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk50mhz);
    #1;
    check("reset_mid_no_done", done_cnt - d0, 0);
    check("reset_mid_no_rx_valid", rxv_cnt - v0, 0);
    run(1'b1, 8'h15, 2, 0, 1'b0, 102, "after_reset");
    txq.delete();
    resp = '{8'h77};
    for (int k = 0; k < 255; k++) begin
      txq.push_back(8'(k * 37 + 11));
      resp.push_back(8'(k) ^ 8'h6B);
    end
    run(1'b1, 8'hC9, 255, 0, 1'b0, 8451, "len255");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
